conv_frame_sched: RTL and testbench

CONV_FRAME_SCHED -- requirements
Module: conv_frame_sched

---
 rtl/conv_frame_sched.sv | 110 +++++++++++
 tb/tb_conv_frame_sched.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_frame_sched.sv
// conv_frame_sched: sequences host pixel loads into a shared image RAM and
// hands each loaded frame to a convolution engine, with a per-frame timeout.
module conv_frame_sched #(
    parameter int AddressBitWidth    = 17,
    parameter int DataBitWidth       = 12,
    parameter int FrameCountBitWidth = 8,
    parameter int TimeoutCycles      = 1024
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          go,
    input  logic [FrameCountBitWidth-1:0] num_frames,
    input  logic [AddressBitWidth-1:0]    frame_pixels,
    input  logic                          host_valid,
    input  logic [DataBitWidth-1:0]       host_data,
    output logic                          host_ready,
    output logic                          mem_we,
    output logic [AddressBitWidth-1:0]    mem_addr,
    output logic [DataBitWidth-1:0]       mem_wdata,
    input  logic [AddressBitWidth-1:0]    conv_read_addr,
    output logic                          conv_start,
    output logic                          conv_rst,
    input  logic                          conv_ready,
    output logic                          busy,
    output logic                          done,
    output logic                          err,
    output logic [FrameCountBitWidth-1:0] frame_cnt
);
    localparam int TmoW = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
    localparam logic [TmoW-1:0] TmoLast = TmoW'(TimeoutCycles - 1);

    typedef enum logic [2:0] {IDLE, LOAD, START, CONV, ACK, DONE} state_t;

    state_t                        state_q;
    logic [AddressBitWidth-1:0]    load_addr_q;
    logic [AddressBitWidth-1:0]    frame_pixels_q;
    logic [FrameCountBitWidth-1:0] num_frames_q;
    logic [FrameCountBitWidth-1:0] frame_cnt_q;
    logic [TmoW-1:0]               tmo_q;
    logic                          err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            load_addr_q    <= '0;
            frame_pixels_q <= '0;
            num_frames_q   <= '0;
            frame_cnt_q    <= '0;
            tmo_q          <= '0;
            err_q          <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (go && num_frames != '0 && frame_pixels != '0) begin
                        num_frames_q   <= num_frames;
                        frame_pixels_q <= frame_pixels;
                        load_addr_q    <= '0;
                        frame_cnt_q    <= '0;
                        err_q          <= 1'b0;
                        state_q        <= LOAD;
                    end else if (go) begin
                        state_q <= DONE;
                    end
                end
                LOAD: begin
                    if (host_valid) begin
                        load_addr_q <= load_addr_q + 1'b1;
                        if (load_addr_q == frame_pixels_q - 1'b1) state_q <= START;
                    end
                end
                START: state_q <= CONV;
                CONV: begin
                    tmo_q <= tmo_q + 1'b1;
                    if (conv_ready) begin
                        tmo_q   <= '0;
                        state_q <= ACK;
                    end else if (tmo_q == TmoLast) begin
                        tmo_q   <= '0;
                        err_q   <= 1'b1;
                        state_q <= ACK;
                    end
                end
                ACK: begin
                    frame_cnt_q <= frame_cnt_q + 1'b1;
                    if (frame_cnt_q + 1'b1 == num_frames_q || err_q) begin
                        state_q <= DONE;
                    end else begin
                        load_addr_q <= '0;
                        state_q     <= LOAD;
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
            // a request arriving mid-job is dropped but flagged
            if (go && state_q != IDLE) err_q <= 1'b1;
        end
    end

    assign busy       = state_q != IDLE;
    assign done       = state_q == DONE;
    assign host_ready = state_q == LOAD;
    assign mem_we     = host_ready & host_valid;
    assign mem_addr   = (state_q == CONV) ? conv_read_addr : load_addr_q;
    assign mem_wdata  = host_data;
    assign conv_start = state_q == START;
    assign conv_rst   = rst | (state_q == ACK);
    assign err        = err_q;
    assign frame_cnt  = frame_cnt_q;
endmodule

// File: tb/tb_conv_frame_sched.sv
// tb_conv_frame_sched: directed checks of load/convolve sequencing, timeout,
// zero-length jobs, busy-go handling and asynchronous reset.
module tb_conv_frame_sched;
    localparam int AW = 17;
    localparam int DW = 12;
    localparam int FW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          go = 1'b0;
    logic [FW-1:0] num_frames = '0;
    logic [AW-1:0] frame_pixels = '0;
    logic          host_valid = 1'b0;
    logic [DW-1:0] host_data = '0;
    logic          host_ready;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [AW-1:0] conv_read_addr = '0;
    logic          conv_start;
    logic          conv_rst;
    logic          conv_ready = 1'b0;
    logic          busy;
    logic          done;
    logic          err;
    logic [FW-1:0] frame_cnt;

    always #5 clk = ~clk;

    conv_frame_sched #(
        .AddressBitWidth(AW),
        .DataBitWidth(DW),
        .FrameCountBitWidth(FW),
        .TimeoutCycles(16)
    ) dut (
        .clk(clk), .rst(rst), .go(go), .num_frames(num_frames),
        .frame_pixels(frame_pixels), .host_valid(host_valid), .host_data(host_data),
        .host_ready(host_ready), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .conv_read_addr(conv_read_addr),
        .conv_start(conv_start), .conv_rst(conv_rst), .conv_ready(conv_ready),
        .busy(busy), .done(done), .err(err), .frame_cnt(frame_cnt)
    );

    int tests = 0;
    int fails = 0;

    // event monitor: counts and timestamps of DUT activity, sampled at each edge
    int cyc = 0, we_cnt = 0, bad_we = 0, start_cnt = 0, crst_cnt = 0, done_cnt = 0;
    int t_go = 0, t_start = 0, t_ack = 0, t_done = 0, start_we = 0;
    logic [AW-1:0] wlog [0:255];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_we) begin
            wlog[we_cnt % 256] <= mem_addr;
            we_cnt <= we_cnt + 1;
        end
        if (mem_we && !host_valid) bad_we <= bad_we + 1;
        if (conv_start) begin
            start_cnt <= start_cnt + 1;
            t_start   <= cyc;
            start_we  <= we_cnt;
        end
        if (conv_rst && !rst) begin
            crst_cnt <= crst_cnt + 1;
            t_ack    <= cyc;
        end
        if (done) begin
            done_cnt <= done_cnt + 1;
            t_done   <= cyc;
        end
        if (go) t_go <= cyc;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic start_job(input int nf, input int fp);
        go = 1'b1;
        num_frames = FW'(nf);
        frame_pixels = AW'(fp);
        @(negedge clk);
        go = 1'b0;
    endtask

    task automatic load(input int n, input bit toggle);
        int sent = 0;
        for (int k = 0; k < 200 && sent < n; k++) begin
            host_valid = toggle ? (k % 2 == 0) : 1'b1;
            host_data = DW'(k * 37 + 5);
            #1;
            if (sent == 0) begin
                chk("load_we", mem_we, 1);
                chk("load_addr0", mem_addr, 0);
                chk("load_wdata", mem_wdata, host_data);
            end else if (!host_valid) begin
                chk("gap_we", mem_we, 0);
                chk("gap_ready", host_ready, 1);
            end
            if (host_valid) sent++;
            @(negedge clk);
        end
        host_valid = 1'b0;
        chk("load_count", sent, n);
    endtask

    task automatic conv_frame(input int d);
        for (int i = 0; i < 8 && !conv_start; i++) @(negedge clk);
        chk("conv_start", conv_start, 1);
        @(negedge clk);
        conv_read_addr = 17'h1A5A0 + AW'(d);
        #1;
        chk("conv_addr", mem_addr, conv_read_addr);
        chk("conv_we", mem_we, 0);
        chk("start_1cyc", conv_start, 0);
        repeat (d) @(negedge clk);
        conv_ready = 1'b1;
        @(negedge clk);
        chk("ack_rst", conv_rst, 1);
        conv_ready = 1'b0;
    endtask

    task automatic chk_seq(input string tag, input int base, input int n);
        int bad = 0;
        for (int i = 0; i < n; i++) if (wlog[(base + i) % 256] !== AW'(i)) bad++;
        chk(tag, bad, 0);
    endtask

    initial begin
        int base, s0, c0, d0, b0;
        // reset state
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_ready", host_ready, 0);
        chk("rst_we", mem_we, 0);
        chk("rst_start", conv_start, 0);
        chk("rst_fcnt", frame_cnt, 0);
        chk("rst_convrst", conv_rst, 1);
        @(negedge clk);
        rst = 1'b0;
        #1 chk("rel_convrst", conv_rst, 0);
        @(negedge clk);

        // single frame, host_valid held high
        start_job(1, 25);
        chk("t1_busy", busy, 1);
        chk("t1_ready", host_ready, 1);
        base = we_cnt; s0 = start_cnt;
        load(25, 1'b0);
        conv_frame(3);
        chk("t1_ack_fcnt", frame_cnt, 0);
        @(negedge clk);
        chk("t1_done", done, 1);
        chk("t1_fcnt", frame_cnt, 1);
        @(negedge clk);
        #1;
        chk("t1_idle_done", done, 0);
        chk("t1_idle_busy", busy, 0);
        chk("t1_idle_addr", mem_addr, 25);
        chk("t1_writes", we_cnt - base, 25);
        chk_seq("t1_addr_seq", base, 25);
        chk("t1_starts", start_cnt - s0, 1);
        chk("t1_done_lat", t_done - t_ack, 1);

        // host_valid toggling every other cycle
        start_job(1, 25);
        base = we_cnt; b0 = bad_we;
        load(25, 1'b1);
        conv_frame(2);
        @(negedge clk);
        chk("t2_done", done, 1);
        @(negedge clk);
        chk("t2_writes", we_cnt - base, 25);
        chk_seq("t2_addr_seq", base, 25);
        chk("t2_bad_we", bad_we - b0, 0);
        chk("t2_start_after", start_we - base, 25);

        // three frames
        base = we_cnt; s0 = start_cnt; c0 = crst_cnt; d0 = done_cnt;
        start_job(3, 4);
        for (int f = 0; f < 3; f++) begin
            load(4, 1'b0);
            conv_frame(f + 1);
            chk("t3_ack_fcnt", frame_cnt, f);
            @(negedge clk);
        end
        chk("t3_done", done, 1);
        chk("t3_fcnt", frame_cnt, 3);
        @(negedge clk);
        chk("t3_fcnt_hold", frame_cnt, 3);
        chk("t3_busy", busy, 0);
        chk("t3_convrst", crst_cnt - c0, 3);
        chk("t3_starts", start_cnt - s0, 3);
        chk("t3_dones", done_cnt - d0, 1);
        chk("t3_writes", we_cnt - base, 12);

        // zero-length jobs go straight to DONE
        base = we_cnt; s0 = start_cnt;
        start_job(0, 25);
        chk("t4_done", done, 1);
        chk("t4_busy", busy, 1);
        @(negedge clk);
        chk("t4_idle", busy, 0);
        chk("t4_done_lat", t_done - t_go, 1);
        start_job(2, 0);
        chk("t4_done_fp0", done, 1);
        @(negedge clk);
        chk("t4_writes", we_cnt - base, 0);
        chk("t4_starts", start_cnt - s0, 0);
        chk("t4_fcnt_hold", frame_cnt, 3);

        // CONV timeout with conv_ready stuck low
        start_job(1, 4);
        load(4, 1'b0);
        chk("t5_start", conv_start, 1);
        for (int i = 0; i < 40 && !conv_rst; i++) @(negedge clk);
        chk("t5_ack", conv_rst, 1);
        chk("t5_err", err, 1);
        @(negedge clk);
        chk("t5_done", done, 1);
        @(negedge clk);
        chk("t5_conv_cycles", t_ack - t_start - 1, 16);
        chk("t5_err_sticky", err, 1);

        // go while busy: ignored, flags err, ends job after current frame
        start_job(2, 4);
        chk("t7_err_clr", err, 0);
        go = 1'b1; num_frames = 8'd9;
        @(negedge clk);
        go = 1'b0;
        chk("t7_err", err, 1);
        chk("t7_ready", host_ready, 1);
        load(4, 1'b0);
        conv_frame(1);
        @(negedge clk);
        chk("t7_done", done, 1);
        chk("t7_fcnt", frame_cnt, 1);
        @(negedge clk);

        // reset during CONV of frame 2 of 3
        d0 = done_cnt;
        start_job(3, 4);
        chk("t6_err_clr", err, 0);
        load(4, 1'b0);
        conv_frame(1);
        @(negedge clk);
        load(4, 1'b0);
        for (int i = 0; i < 8 && !conv_start; i++) @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("t6_busy", busy, 0);
        chk("t6_convrst", conv_rst, 1);
        chk("t6_ready", host_ready, 0);
        chk("t6_start", conv_start, 0);
        chk("t6_fcnt", frame_cnt, 0);
        chk("t6_done", done, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        start_job(1, 4);
        chk("t6_go_after_rst", busy, 1);
        chk("t6_no_done", done_cnt - d0, 0);
        load(4, 1'b0);
        conv_frame(1);
        @(negedge clk);
        chk("t6_final_done", done, 1);
        chk("t6_final_fcnt", frame_cnt, 1);
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1);
    end
endmodule
